// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS multiply/divide unit: radix-2 shift-add multiply, restoring divide, HI/LO registers.
// Latency WIDTH+1 cycles after launch; busy_o stalls the pipeline, start_i ignored while busy.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             abort_i,
  input  logic             wr_hi_i,
  input  logic             wr_lo_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_launch;
  logic               w_finish;

  logic               r_is_div;
  logic               r_sign_q;
  logic               r_sign_r;
  logic               r_dbz;
  logic               r_done;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_orig_a;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_acc;

  // op_i[0]=0 selects the signed variants (MULT, DIV)
  logic               w_signed_op;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  assign w_signed_op = ~op_i[0];
  assign w_a_mag     = (w_signed_op && a_i[WIDTH-1]) ? -a_i : a_i;
  assign w_b_mag     = (w_signed_op && b_i[WIDTH-1]) ? -b_i : b_i;

  // Multiply: acc = {partial, multiplier}; add multiplicand when LSB set, shift right
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_acc;

  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; shift left, trial-subtract divisor
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_div_acc;

  assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
  assign w_div_acc   = w_div_diff[WIDTH]
                     ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                     : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_prod = r_sign_q ? -r_acc : r_acc;

  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_dbz) begin
        w_res_hi = r_orig_a;
        w_res_lo = '1;
      end else begin
        w_res_hi = r_sign_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        w_res_lo = r_sign_q ? -r_acc[WIDTH-1:0]       : r_acc[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          w_launch    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_state_nxt = ST_FIX;
        end
      end
      ST_FIX: begin
        w_state_nxt = ST_IDLE;
        w_finish    = ~abort_i;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_state  <= ST_IDLE;
      r_done   <= 1'b0;
      r_is_div <= 1'b0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_dbz    <= 1'b0;
      r_cnt    <= '0;
      r_opnd   <= '0;
      r_orig_a <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_finish;

      // MTHI/MTLO only land while idle; a same-cycle launch overwrites them later
      if (r_state == ST_IDLE) begin
        if (wr_hi_i) r_hi <= wdata_i;
        if (wr_lo_i) r_lo <= wdata_i;
      end

      if (w_launch) begin
        r_is_div <= op_i[1];
        r_sign_q <= w_signed_op & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        r_sign_r <= w_signed_op & a_i[WIDTH-1];
        r_dbz    <= op_i[1] & (b_i == '0);
        r_cnt    <= '0;
        r_orig_a <= a_i;
        r_opnd   <= op_i[1] ? w_b_mag : w_a_mag;
        r_acc    <= {{WIDTH{1'b0}}, (op_i[1] ? w_a_mag : w_b_mag)};
      end

      if (r_state == ST_RUN) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_acc <= r_is_div ? w_div_acc : w_mul_acc;
      end

      if (w_finish) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  assign busy_o = (r_state != ST_IDLE);
  assign done_o = r_done;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: MULT/MULTU/DIV/DIVU results, latency, abort, MTHI/MTLO, reset.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        abort_i;
  logic        wr_hi_i;
  logic        wr_lo_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .abort_i(abort_i), .wr_hi_i(wr_hi_i),
    .wr_lo_i(wr_lo_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1ns after an edge; returns 1ns after the launch edge E0
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    tick();
    start_i = 1'b0;
  endtask

  // Counts cycles with busy_o high; bounded so a stuck DUT still reaches the summary
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (busy_o && cyc < 100) begin
      cyc++;
      tick();
    end
  endtask

  task automatic preload(input logic [31:0] v);
    wr_hi_i = 1'b1; wr_lo_i = 1'b1; wdata_i = v;
    tick();
    wr_hi_i = 1'b0; wr_lo_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    repeat (3) tick();
    n_chk++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    n_chk++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done_o); end
    n_chk++; if (hi_o !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h expected 00000000", hi_o); end
    n_chk++; if (lo_o !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h expected 00000000", lo_o); end
    reset_ni = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    int cyc;
    launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(cyc);
    n_chk++; if (cyc !== 33) begin n_err++; $display("FAIL multu_busy_cycles: got %0d expected 33", cyc); end
    n_chk++; if (done_o !== 1'b1) begin n_err++; $display("FAIL multu_done: got %b expected 1", done_o); end
    n_chk++; if (hi_o !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_hi: got %h expected fffffffe", hi_o); end
    n_chk++; if (lo_o !== 32'h00000001) begin n_err++; $display("FAIL multu_lo: got %h expected 00000001", lo_o); end
    tick();
    n_chk++; if (done_o !== 1'b0) begin n_err++; $display("FAIL done_pulse_width: got %b expected 0", done_o); end

    launch(OP_MULT, 32'hFFFFFFFD, 32'd7);
    wait_done(cyc);
    n_chk++; if (hi_o !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_neg_hi: got %h expected ffffffff", hi_o); end
    n_chk++; if (lo_o !== 32'hFFFFFFEB) begin n_err++; $display("FAIL mult_neg_lo: got %h expected ffffffeb", lo_o); end

    launch(OP_MULT, 32'h80000000, 32'h80000000);
    wait_done(cyc);
    n_chk++; if (hi_o !== 32'h40000000) begin n_err++; $display("FAIL mult_min_hi: got %h expected 40000000", hi_o); end
    n_chk++; if (lo_o !== 32'h00000000) begin n_err++; $display("FAIL mult_min_lo: got %h expected 00000000", lo_o); end
  endtask

  task automatic test_div();
    int cyc;
    launch(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(cyc);
    n_chk++; if (lo_o !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_neg_lo: got %h expected fffffffd", lo_o); end
    n_chk++; if (hi_o !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_neg_hi: got %h expected ffffffff", hi_o); end

    launch(OP_DIVU, 32'd100, 32'd7);
    wait_done(cyc);
    n_chk++; if (lo_o !== 32'd14) begin n_err++; $display("FAIL divu_lo: got %h expected 0000000e", lo_o); end
    n_chk++; if (hi_o !== 32'd2) begin n_err++; $display("FAIL divu_hi: got %h expected 00000002", hi_o); end

    launch(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(cyc);
    n_chk++; if (lo_o !== 32'h80000000) begin n_err++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo_o); end
    n_chk++; if (hi_o !== 32'h00000000) begin n_err++; $display("FAIL div_ovf_hi: got %h expected 00000000", hi_o); end

    launch(OP_DIVU, 32'd7, 32'd0);
    wait_done(cyc);
    n_chk++; if (cyc !== 33) begin n_err++; $display("FAIL divz_busy_cycles: got %0d expected 33", cyc); end
    n_chk++; if (done_o !== 1'b1) begin n_err++; $display("FAIL divz_done: got %b expected 1", done_o); end
    n_chk++; if (hi_o !== 32'd7) begin n_err++; $display("FAIL divz_hi: got %h expected 00000007", hi_o); end
    n_chk++; if (lo_o !== 32'hFFFFFFFF) begin n_err++; $display("FAIL divz_lo: got %h expected ffffffff", lo_o); end

    launch(OP_DIV, 32'hFFFFFFF9, 32'd0);
    wait_done(cyc);
    n_chk++; if (hi_o !== 32'hFFFFFFF9) begin n_err++; $display("FAIL sdivz_hi: got %h expected fffffff9", hi_o); end
    n_chk++; if (lo_o !== 32'hFFFFFFFF) begin n_err++; $display("FAIL sdivz_lo: got %h expected ffffffff", lo_o); end
  endtask

  task automatic test_ignore_while_busy();
    int cyc;
    preload(32'h1234);
    n_chk++; if (hi_o !== 32'h1234) begin n_err++; $display("FAIL preload_hi: got %h expected 00001234", hi_o); end
    n_chk++; if (lo_o !== 32'h1234) begin n_err++; $display("FAIL preload_lo: got %h expected 00001234", lo_o); end
    launch(OP_MULTU, 32'd5, 32'd6);
    repeat (4) tick();
    start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7;
    wr_hi_i = 1'b1; wr_lo_i = 1'b1; wdata_i = 32'hDEAD;
    tick();
    start_i = 1'b0; wr_hi_i = 1'b0; wr_lo_i = 1'b0;
    n_chk++; if (lo_o !== 32'h1234) begin n_err++; $display("FAIL busy_wr_lo: got %h expected 00001234", lo_o); end
    n_chk++; if (hi_o !== 32'h1234) begin n_err++; $display("FAIL busy_wr_hi: got %h expected 00001234", hi_o); end
    wait_done(cyc);
    n_chk++; if (done_o !== 1'b1) begin n_err++; $display("FAIL busy_start_done: got %b expected 1", done_o); end
    n_chk++; if (hi_o !== 32'd0) begin n_err++; $display("FAIL busy_start_hi: got %h expected 00000000", hi_o); end
    n_chk++; if (lo_o !== 32'd30) begin n_err++; $display("FAIL busy_start_lo: got %h expected 0000001e", lo_o); end
    tick();
  endtask

  task automatic test_abort();
    preload(32'h1234);
    launch(OP_MULTU, 32'd5, 32'd6);
    repeat (9) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    n_chk++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy_o); end
    n_chk++; if (done_o !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b expected 0", done_o); end
    n_chk++; if (hi_o !== 32'h1234) begin n_err++; $display("FAIL abort_hi: got %h expected 00001234", hi_o); end
    n_chk++; if (lo_o !== 32'h1234) begin n_err++; $display("FAIL abort_lo: got %h expected 00001234", lo_o); end
    tick();
    n_chk++; if (done_o !== 1'b0) begin n_err++; $display("FAIL abort_done_late: got %b expected 0", done_o); end
    start_i = 1'b1; abort_i = 1'b1; op_i = OP_MULTU; a_i = 32'd2; b_i = 32'd3;
    tick();
    start_i = 1'b0; abort_i = 1'b0;
    n_chk++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL abort_start_idle_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_wr_with_start();
    int cyc;
    wr_hi_i = 1'b1; wr_lo_i = 1'b1; wdata_i = 32'hABCD;
    launch(OP_MULTU, 32'd3, 32'd4);
    wr_hi_i = 1'b0; wr_lo_i = 1'b0;
    n_chk++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL wrstart_busy: got %b expected 1", busy_o); end
    n_chk++; if (hi_o !== 32'hABCD) begin n_err++; $display("FAIL wrstart_hi: got %h expected 0000abcd", hi_o); end
    n_chk++; if (lo_o !== 32'hABCD) begin n_err++; $display("FAIL wrstart_lo: got %h expected 0000abcd", lo_o); end
    wait_done(cyc);
    n_chk++; if (hi_o !== 32'd0) begin n_err++; $display("FAIL wrstart_res_hi: got %h expected 00000000", hi_o); end
    n_chk++; if (lo_o !== 32'd12) begin n_err++; $display("FAIL wrstart_res_lo: got %h expected 0000000c", lo_o); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    preload(32'h1234);
    launch(OP_DIVU, 32'd100, 32'd7);
    repeat (19) tick();
    reset_ni = 1'b0;
    tick();
    reset_ni = 1'b1;
    n_chk++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy_o); end
    n_chk++; if (done_o !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b expected 0", done_o); end
    n_chk++; if (hi_o !== 32'd0) begin n_err++; $display("FAIL midrst_hi: got %h expected 00000000", hi_o); end
    n_chk++; if (lo_o !== 32'd0) begin n_err++; $display("FAIL midrst_lo: got %h expected 00000000", lo_o); end
    launch(OP_DIVU, 32'd100, 32'd7);
    wait_done(cyc);
    n_chk++; if (cyc !== 33) begin n_err++; $display("FAIL relaunch_busy_cycles: got %0d expected 33", cyc); end
    n_chk++; if (lo_o !== 32'd14) begin n_err++; $display("FAIL relaunch_lo: got %h expected 0000000e", lo_o); end
    n_chk++; if (hi_o !== 32'd2) begin n_err++; $display("FAIL relaunch_hi: got %h expected 00000002", hi_o); end
  endtask

  initial begin
    reset_ni = 1'b0; start_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
    abort_i = 1'b0; wr_hi_i = 1'b0; wr_lo_i = 1'b0; wdata_i = '0;
    test_reset();
    test_mult();
    test_div();
    test_ignore_while_busy();
    test_abort();
    test_wr_with_start();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
